// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit.
// The control decoder uses the same op encodings.
package muldiv_unit_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the CPU datapath (master) and the muldiv unit (slave).
interface muldiv_unit_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_by_zero;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result_lo, result_hi, div_by_zero, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_lo, result_hi, div_by_zero, zero
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned shift-add multiplier / restoring divider.
// Takes WIDTH iterations per operation; a divide by zero finishes immediately.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;

    logic             sub;
    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic [WIDTH:0]   add_s;
    logic             fits;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] lo_nx;

    // One WIDTH+1-bit adder serves both the multiply accumulate and the divide trial subtraction.
    // A shifted remainder with its top bit set always exceeds the divisor.
    always_comb begin
        sub    = (state == ST_DIV);
        add_x  = sub ? {acc, lo[WIDTH-1]} : {1'b0, acc};
        add_y  = (sub || lo[0]) ? {1'b0, dvs} : '0;
        add_s  = add_x + (add_y ^ {(WIDTH+1){sub}}) + {{WIDTH{1'b0}}, sub};
        fits   = add_x[WIDTH] | ~add_s[WIDTH];
        acc_nx = add_s[WIDTH:1];
        lo_nx  = {add_s[0], lo[WIDTH-1:1]};
        if (sub) begin
            acc_nx = fits ? add_s[WIDTH-1:0] : add_x[WIDTH-1:0];
            lo_nx  = {lo[WIDTH-2:0], fits};
        end
    end

    // Working registers are separate from the result registers so results stay stable while iterating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            dvs    <= '0;
            acc    <= '0;
            lo     <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            res_lo <= '0;
            res_hi <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        cnt   <= CW'(WIDTH);
                        acc   <= '0;
                        dbz_q <= 1'b0;
                        if (bus.op == OP_MUL) begin
                            dvs    <= bus.a;
                            lo     <= bus.b;
                            busy_q <= 1'b1;
                            state  <= ST_MUL;
                        end else if (bus.b != '0) begin
                            dvs    <= bus.b;
                            lo     <= bus.a;
                            busy_q <= 1'b1;
                            state  <= ST_DIV;
                        end else begin
                            res_lo <= '1;
                            res_hi <= bus.a;
                            dbz_q  <= 1'b1;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc <= acc_nx;
                    lo  <= lo_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        res_hi <= acc_nx;
                        res_lo <= lo_nx;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.result_lo   = res_lo;
    assign bus.result_hi   = res_hi;
    assign bus.zero        = (res_lo == '0);

endmodule
